// File: rtl/simple_rtl_decoder_pkg.sv
// simple_rtl_pkg: shared types and helpers for the simple RTL transfer decoder.
`default_nettype none

package simple_rtl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // The producer derives C from the two LSBs of its counter.
    function automatic logic c_expected(input logic [NIB_W-1:0] nib);
        return nib[1] & nib[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/simple_rtl_decoder.sv
// simple_rtl_decoder: recovers the producer's counter nibble from B/C, checks
// C and +1 continuity, tracks lock and counts errors (saturating).
`default_nettype none

module simple_rtl_decoder
    import simple_rtl_pkg::*;
#(
    parameter int LOCK_CNT   = 2,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_b,
    input  logic             in_c,
    output logic             out_valid,
    output logic [3:0]       out_nib,
    output logic             c_err,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    state_t           state, state_nx;
    logic [NIB_W-1:0] prev;
    logic [3:0]       good, good_nx;
    logic [3:0]       bad, bad_nx;

    logic [NIB_W-1:0] nib;
    logic [NIB_W-1:0] expected;
    logic             nib_match;
    logic             c_bad;
    logic             seq_bad;
    logic             err_hit;
    logic             cnt_sat;

    always_comb begin
        nib       = ~in_b;
        expected  = prev + 4'd1;
        nib_match = (nib == expected);
        c_bad     = (in_c != c_expected(nib));
        state_nx  = state;
        good_nx   = good;
        bad_nx    = bad;
        seq_bad   = 1'b0;

        if (in_valid) begin
            case (state)
                HUNT: begin
                    state_nx = TRACK;
                    good_nx  = 4'd0;
                end
                TRACK: begin
                    if (nib_match) begin
                        good_nx = good + 4'd1;
                        if (good + 4'd1 == LOCK_N) begin
                            state_nx = LOCKED;
                            bad_nx   = 4'd0;
                        end
                    end else begin
                        good_nx = 4'd0;
                    end
                end
                LOCKED: begin
                    if (nib_match) begin
                        bad_nx = 4'd0;
                    end else begin
                        seq_bad = 1'b1;
                        bad_nx  = bad + 4'd1;
                        if (bad + 4'd1 == UNLOCK_N) begin
                            state_nx = HUNT;
                        end
                    end
                end
                default: begin
                    state_nx = HUNT;
                end
            endcase
        end

        // A sample carrying both errors still counts once.
        err_hit = in_valid & (c_bad | seq_bad);
        cnt_sat = &err_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            good      <= '0;
            bad       <= '0;
            out_valid <= 1'b0;
            out_nib   <= '0;
            c_err     <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            good      <= good_nx;
            bad       <= bad_nx;
            out_valid <= in_valid;
            c_err     <= in_valid & c_bad;
            seq_err   <= seq_bad;
            locked    <= (state_nx == LOCKED);
            if (in_valid) begin
                prev    <= nib;
                out_nib <= nib;
            end
            if (err_hit && !cnt_sat) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simple_rtl_decoder.sv
// tb_simple_rtl_decoder: directed vectors with hand-computed expectations for
// the decoder (default instance plus a CNT_W=2 instance sharing the inputs).
`default_nettype none

module tb_simple_rtl_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_b;
    logic       in_c;
    logic       out_valid;
    logic [3:0] out_nib;
    logic       c_err;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_count;

    logic       out_valid2;
    logic [3:0] out_nib2;
    logic       c_err2;
    logic       seq_err2;
    logic       locked2;
    logic [1:0] err_count2;

    int checks   = 0;
    int failures = 0;

    simple_rtl_decoder #(.LOCK_CNT(2), .UNLOCK_CNT(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_nib(out_nib), .c_err(c_err), .seq_err(seq_err),
        .locked(locked), .err_count(err_count)
    );

    simple_rtl_decoder #(.LOCK_CNT(2), .UNLOCK_CNT(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid2), .out_nib(out_nib2), .c_err(c_err2), .seq_err(seq_err2),
        .locked(locked2), .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic good_c(input logic [3:0] nib);
        return nib[1] & nib[0];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_nib"},   32'(out_nib),   32'd0);
        check({tag, ".c_err"},     32'(c_err),     32'd0);
        check({tag, ".seq_err"},   32'(seq_err),   32'd0);
        check({tag, ".locked"},    32'(locked),    32'd0);
        check({tag, ".err_count"}, 32'(err_count), 32'd0);
        check({tag, ".err_count2"}, 32'(err_count2), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check_all_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One valid sample; outputs checked 1 ns after the capturing edge.
    task automatic send(input string tag, input logic [3:0] nib, input logic c,
                        input logic ec, input logic es, input logic el, input int ecnt);
        int ecnt2;
        ecnt2 = (ecnt > 3) ? 3 : ecnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_b     = ~nib;
        in_c     = c;
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out_nib"},   32'(out_nib),   32'(nib));
        check({tag, ".c_err"},     32'(c_err),     32'(ec));
        check({tag, ".seq_err"},   32'(seq_err),   32'(es));
        check({tag, ".locked"},    32'(locked),    32'(el));
        check({tag, ".err_count"}, 32'(err_count), 32'(ecnt));
        check({tag, ".err_count2"}, 32'(err_count2), 32'(ecnt2));
        in_valid = 1'b0;
    endtask

    task automatic idle(input string tag, input logic el, input int ecnt);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".c_err"},     32'(c_err),     32'd0);
        check({tag, ".seq_err"},   32'(seq_err),   32'd0);
        check({tag, ".locked"},    32'(locked),    32'(el));
        check({tag, ".err_count"}, 32'(err_count), 32'(ecnt));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_b     = 4'h0;
        in_c     = 1'b0;
        #3;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp 0..5 with C held low: only nib 3 disagrees with its C.
        send("s1_n0", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send("s1_n1", 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send("s1_n2", 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send("s1_n3", 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        send("s1_n4", 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        send("s1_n5", 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        idle("s1_idle", 1'b1, 1);
        idle("s1_idle2", 1'b1, 1);

        // Wrap-around F -> 0 is in sequence.
        do_reset("rst2");
        send("s2_nB", 4'hB, good_c(4'hB), 1'b0, 1'b0, 1'b0, 0);
        send("s2_nC", 4'hC, good_c(4'hC), 1'b0, 1'b0, 1'b0, 0);
        send("s2_nD", 4'hD, good_c(4'hD), 1'b0, 1'b0, 1'b1, 0);
        send("s2_nE", 4'hE, good_c(4'hE), 1'b0, 1'b0, 1'b1, 0);
        send("s2_nF", 4'hF, good_c(4'hF), 1'b0, 1'b0, 1'b1, 0);
        send("s2_n0", 4'h0, good_c(4'h0), 1'b0, 1'b0, 1'b1, 0);
        send("s2_n1", 4'h1, good_c(4'h1), 1'b0, 1'b0, 1'b1, 0);

        // Single jump; the following in-sequence sample must clear bad, so two
        // more misses still leave the lock intact.
        do_reset("rst3");
        send("s3_n2", 4'h2, good_c(4'h2), 1'b0, 1'b0, 1'b0, 0);
        send("s3_n3", 4'h3, good_c(4'h3), 1'b0, 1'b0, 1'b0, 0);
        send("s3_n4", 4'h4, good_c(4'h4), 1'b0, 1'b0, 1'b1, 0);
        send("s3_n9", 4'h9, good_c(4'h9), 1'b0, 1'b1, 1'b1, 1);
        send("s3_nA", 4'hA, good_c(4'hA), 1'b0, 1'b0, 1'b1, 1);
        send("s3_n0", 4'h0, good_c(4'h0), 1'b0, 1'b1, 1'b1, 2);
        send("s3_n5", 4'h5, good_c(4'h5), 1'b0, 1'b1, 1'b1, 3);
        send("s3_n6", 4'h6, good_c(4'h6), 1'b0, 1'b0, 1'b1, 3);

        // Three misses in a row unlock; then HUNT -> TRACK -> needs two matches.
        do_reset("rst4");
        send("s4_n0", 4'h0, good_c(4'h0), 1'b0, 1'b0, 1'b0, 0);
        send("s4_n1", 4'h1, good_c(4'h1), 1'b0, 1'b0, 1'b0, 0);
        send("s4_n2", 4'h2, good_c(4'h2), 1'b0, 1'b0, 1'b1, 0);
        send("s4_m1", 4'h7, good_c(4'h7), 1'b0, 1'b1, 1'b1, 1);
        send("s4_m2", 4'h7, good_c(4'h7), 1'b0, 1'b1, 1'b1, 2);
        send("s4_m3", 4'h0, good_c(4'h0), 1'b0, 1'b1, 1'b0, 3);
        send("s4_hunt", 4'h1, good_c(4'h1), 1'b0, 1'b0, 1'b0, 3);
        send("s4_trk1", 4'h2, good_c(4'h2), 1'b0, 1'b0, 1'b0, 3);
        send("s4_trk2", 4'h3, good_c(4'h3), 1'b0, 1'b0, 1'b1, 3);

        // C errors on every sample: the CNT_W=2 instance saturates at 3; the
        // final sample carries both errors and counts once.
        do_reset("rst5");
        send("s5_n0", 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        send("s5_n1", 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        send("s5_n2", 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 3);
        send("s5_n3", 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        send("s5_n4", 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 5);
        send("s5_both", 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 6);

        // Asynchronous reset while locked with a c_err pulse showing.
        do_reset("rst6");
        send("s6_n4", 4'h4, good_c(4'h4), 1'b0, 1'b0, 1'b0, 0);
        send("s6_n5", 4'h5, good_c(4'h5), 1'b0, 1'b0, 1'b0, 0);
        send("s6_n6", 4'h6, good_c(4'h6), 1'b0, 1'b0, 1'b1, 0);
        send("s6_n7", 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("s6_async");
        @(negedge clk);
        rst_n = 1'b1;
        send("s6_r8", 4'h8, good_c(4'h8), 1'b0, 1'b0, 1'b0, 0);
        send("s6_r9", 4'h9, good_c(4'h9), 1'b0, 1'b0, 1'b0, 0);
        send("s6_rA", 4'hA, good_c(4'hA), 1'b0, 1'b0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
